// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream between NumIn requesters.
// The output side is a two-slot spill buffer: slot A drives the outputs and
// slot B only catches a beat when A is full and stalled, so the output is
// registered and inp_ready_o never depends on oup_ready_i.
module stream_rr_arbiter #(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned IdxWidth = $clog2(NumIn)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumIn-1:0]           inp_valid_i,
    output logic [NumIn-1:0]           inp_ready_o,
    input  logic [NumIn*DataWidth-1:0] inp_data_i,
    output logic                       oup_valid_o,
    input  logic                       oup_ready_i,
    output logic [DataWidth-1:0]       oup_data_o,
    output logic [IdxWidth-1:0]        oup_idx_o
);

    logic [IdxWidth-1:0]  ptr;
    logic [IdxWidth-1:0]  ptr_next;

    logic                 a_full;
    logic [DataWidth-1:0] a_data;
    logic [IdxWidth-1:0]  a_idx;
    logic                 b_full;
    logic [DataWidth-1:0] b_data;
    logic [IdxWidth-1:0]  b_idx;

    logic                 can_accept;
    logic                 grant_found;
    logic [IdxWidth-1:0]  grant_idx;
    logic [IdxWidth-1:0]  cand_idx;
    logic [DataWidth-1:0] sel_data;
    logic                 hs_in;
    logic                 hs_out;
    logic                 to_a;

    // Only register state decides acceptance, cutting the ready path.
    assign can_accept = !(a_full && b_full);

    // Rotating priority search starting at ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            cand_idx = IdxWidth'((32'(ptr) + k) % NumIn);
            if (!grant_found && inp_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            if (grant_idx == IdxWidth'(i)) begin
                sel_data = inp_data_i[i*DataWidth +: DataWidth];
            end
        end
    end

    // Ready decode and handshake qualifiers; ready is held low during reset.
    always_comb begin
        inp_ready_o = '0;
        hs_in       = grant_found && can_accept && !rst_i;
        if (hs_in) begin
            inp_ready_o[grant_idx] = 1'b1;
        end
        hs_out   = a_full && oup_ready_i;
        to_a     = !a_full || (oup_ready_i && !b_full);
        ptr_next = (grant_idx == IdxWidth'(NumIn - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Pointer and two-slot buffer state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr    <= '0;
            a_full <= 1'b0;
            a_data <= '0;
            a_idx  <= '0;
            b_full <= 1'b0;
            b_data <= '0;
            b_idx  <= '0;
        end else begin
            if (hs_in) begin
                ptr <= ptr_next;
            end
            // B full implies A full, so no input can coincide with a B->A move.
            if (hs_out && b_full) begin
                a_data <= b_data;
                a_idx  <= b_idx;
                b_full <= 1'b0;
            end else if (hs_in && to_a) begin
                a_data <= sel_data;
                a_idx  <= grant_idx;
                a_full <= 1'b1;
            end else if (hs_in) begin
                b_data <= sel_data;
                b_idx  <= grant_idx;
                b_full <= 1'b1;
            end else if (hs_out) begin
                a_full <= 1'b0;
            end
        end
    end

    assign oup_valid_o = a_full;
    assign oup_data_o  = a_data;
    assign oup_idx_o   = a_idx;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized bench for stream_rr_arbiter against a queue-based reference model.
module tb_stream_rr_arbiter;

    localparam int NumIn     = 4;
    localparam int DataWidth = 32;
    localparam int IdxWidth  = 2;

    typedef struct packed {
        logic [IdxWidth-1:0]  idx;
        logic [DataWidth-1:0] data;
    } beat_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NumIn-1:0]           inp_valid = '0;
    logic [NumIn-1:0]           inp_ready;
    logic [NumIn*DataWidth-1:0] inp_data = '0;
    logic                       oup_valid;
    logic                       oup_ready = 1'b0;
    logic [DataWidth-1:0]       oup_data;
    logic [IdxWidth-1:0]        oup_idx;

    beat_t                q[$];
    int                   mptr;
    bit                   pend[NumIn];
    logic [DataWidth-1:0] req_data[NumIn];
    int                   checks = 0;
    int                   errors = 0;

    stream_rr_arbiter #(
        .NumIn    (NumIn),
        .DataWidth(DataWidth)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .inp_valid_i(inp_valid),
        .inp_ready_o(inp_ready),
        .inp_data_i (inp_data),
        .oup_valid_o(oup_valid),
        .oup_ready_i(oup_ready),
        .oup_data_o (oup_data),
        .oup_idx_o  (oup_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive requests, compare against the model, advance the model.
    task automatic cycle(input int p_new, input int p_rdy);
        int g;
        logic [NumIn-1:0] exp_ready;
        @(negedge clk);
        for (int i = 0; i < NumIn; i++) begin
            if (!pend[i] && $urandom_range(99) < p_new) begin
                pend[i]     = 1'b1;
                req_data[i] = $urandom;
            end
            inp_valid[i] = pend[i];
            inp_data[i*DataWidth +: DataWidth] = pend[i] ? req_data[i] : DataWidth'($urandom);
        end
        oup_ready = ($urandom_range(99) < p_rdy);
        #1;
        g = -1;
        for (int k = 0; k < NumIn; k++) begin
            if (g < 0 && pend[(mptr + k) % NumIn]) g = (mptr + k) % NumIn;
        end
        exp_ready = '0;
        if (g >= 0 && q.size() < 2) exp_ready[g] = 1'b1;
        check("inp_ready", 64'(inp_ready), 64'(exp_ready));
        check("oup_valid", 64'(oup_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("oup_data", 64'(oup_data), 64'(q[0].data));
            check("oup_idx", 64'(oup_idx), 64'(q[0].idx));
        end
        if (q.size() > 0 && oup_ready) void'(q.pop_front());
        if (exp_ready != '0) begin
            q.push_back({IdxWidth'(g), req_data[g]});
            pend[g] = 1'b0;
            mptr    = (g + 1) % NumIn;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(inp_ready), 64'd0);
        check({tag, "_valid"}, 64'(oup_valid), 64'd0);
        check({tag, "_data"}, 64'(oup_data), 64'd0);
        check({tag, "_idx"}, 64'(oup_idx), 64'd0);
    endtask

    initial begin
        mptr = 0;
        for (int i = 0; i < NumIn; i++) begin
            pend[i]     = 1'b1;
            req_data[i] = $urandom;
            inp_data[i*DataWidth +: DataWidth] = req_data[i];
        end
        inp_valid = '1;
        oup_ready = 1'b1;
        // Held reset with every requester valid.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check_reset_outputs("rst_hold");
        end
        @(posedge clk);
        #1 rst = 1'b0;

        cycle(100, 100);  // first grant must be requester 0
        for (int c = 0; c < 60; c++) cycle(100, 100);
        for (int c = 0; c < 200; c++) cycle(50, 70);
        for (int c = 0; c < 150; c++) cycle(100, 20);
        for (int c = 0; c < 150; c++) cycle(20, 90);
        for (int c = 0; c < 4; c++) cycle(100, 0);
        check("both_slots_full", 64'(q.size()), 64'd2);

        // Reset while both slots hold beats.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        q.delete();
        mptr = 0;
        for (int i = 0; i < NumIn; i++) pend[i] = 1'b0;
        inp_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) cycle(0, 100);
        for (int c = 0; c < 100; c++) cycle(100, 100);
        for (int c = 0; c < 200; c++) cycle(40, 50);
        for (int c = 0; c < 20; c++) cycle(0, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready stream channel between NumIn requesters.
- Output side is a two-slot spill buffer (registered main slot plus spill slot), so the output is fully registered, ready is cut from output to inputs, and one beat per cycle is sustained.
- Used in front of shared AXI channels (e.g. AW/AR muxing from several masters) where each requester drives one channel and the downstream sees a single registered stream plus requester index.

Parameters:
- NumIn, 4, number of requesters; legal range 2..16.
- DataWidth, 32, payload width per requester.
- IdxWidth, $clog2(NumIn), width of the requester index. Derived; do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active high.
- inp_valid_i  in  NumIn  per-requester valid.
- inp_ready_o  out  NumIn  per-requester ready; at most one bit high per cycle.
- inp_data_i  in  NumIn*DataWidth  payloads; requester i occupies bits [i*DataWidth +: DataWidth].
- oup_valid_o  out  1  output valid.
- oup_ready_i  in  1  output ready.
- oup_data_o  out  DataWidth  output payload.
- oup_idx_o  out  IdxWidth  index of the requester that sourced oup_data_o.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - Both slots empty; oup_valid_o=0, oup_data_o=0, oup_idx_o=0.
  - Round-robin pointer ptr=0.
  - inp_ready_o is all 0 for as long as rst_i is high.
- Storage: main slot A drives the outputs; spill slot B is used only when A is full and stalled. Each slot holds {data, idx, full}.
- can_accept = !(A.full && B.full). This depends only on registers, never on oup_ready_i.
- Grant (combinational):
  - g is the first i with inp_valid_i[i]=1, searching ptr, ptr+1, …, NumIn-1, 0, …, ptr-1.
  - inp_ready_o[g] = can_accept; all other bits are 0. If no valid is high, inp_ready_o=0.
  - The grant may change between cycles while no handshake occurs. Requesters must hold valid and data until their own handshake, per the stream rules.
- Pointer: on an input handshake at requester g, ptr <= (g+1) mod NumIn. Without a handshake, ptr holds.
- Input handshake (inp_valid_i[g] && inp_ready_o[g]):
  - If A is empty, or A is draining this cycle (oup_ready_i=1) and B is empty, the beat goes to A.
  - Otherwise the beat goes to B.
- Output handshake (oup_valid_o && oup_ready_i):
  - If B is full, B moves to A and B becomes empty.
  - Otherwise A empties, unless it is refilled by a simultaneous input beat.
- oup_valid_o = A.full. Outputs are stable while oup_valid_o=1 and oup_ready_i=0.
- Latency: one cycle from input handshake to oup_valid_o when A is empty.
- Throughput: one beat per cycle with oup_ready_i held high.
- Ordering: beats leave in acceptance order; no loss or duplication.
- Simultaneous events:
  - A full, B empty, input and output handshake in the same cycle: the new beat loads A, B stays empty.
  - Both slots full: no input is accepted; an output handshake moves B to A, and inputs are accepted again from the next cycle.
- Reset mid-operation discards both slots immediately; no beat is emitted after reset releases until a new input handshake.

Test Plan:
- Reset, then hold rst_i=1 with inp_valid_i=4'b1111 -> inp_ready_o=0, oup_valid_o=0, oup_data_o=0, oup_idx_o=0 throughout. After release, the first grant goes to requester 0.
- Only requester 2 valid, data 0x10,0x11,0x12,0x13 on consecutive cycles, oup_ready_i=1 -> outputs 0x10..0x13 on 4 consecutive cycles, each 1 cycle after acceptance, oup_idx_o=2, no bubbles.
- All four requesters continuously valid, oup_ready_i=1 -> grant/oup_idx_o sequence 0,1,2,3,0,1,… with one beat per cycle.
- Requester 0 continuously valid, oup_ready_i=0 for 4 cycles -> exactly 2 beats accepted (A then B) and inp_ready_o=0 from the 3rd cycle. Then raise oup_ready_i -> beats emerge in acceptance order with no gap, and acceptance resumes the cycle after the first drain.
- ptr=2, only requesters 1 and 3 valid -> 3 is granted first, then 1, then 3 again (ptr skips idle requesters).
- Two beats buffered (A and B full), pulse rst_i for 1 cycle -> oup_valid_o falls asynchronously; after release, no stale beat appears and ptr=0.
